shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift/rotate unit that sits beside `alu` in the execute stage. It takes the counted shift/rotate group (ROL, ROR, ROLC, RORC, SHL, SHR, SHRA) with a count operand. It performs one single-bit step per cycle, tracking carry and overflow, and presents the final value to the same writeback mux that consumes `alu`'s `R`. `alu` continues to serve single-bit and arithmetic ops combinationally. This block handles every shift whose count comes from CL or an immediate.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  4  AluOp value (shift/rotate group).
- `width16`  in  1  1 = word operation, 0 = byte operation (low 8 bits).
- `operand`  in  16  value to shift.
- `count`  in  8  shift count.
- `cf_in`  in  1  current CF, used by ROLC/RORC and on zero count.
- `busy`  out  1  high while an operation is in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse; result and flags are valid.
- `result`  out  16  shifted value, held until the next accepted `start`.
- `cf_out`  out  1  final carry.
- `of_out`  out  1  final overflow.
- `flags_upd`  out  1  qualifies `cf_out` and `of_out`; 0 means the flags must be left unchanged.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On `start`, latch `op`, `width16`, `operand` and `cf_in`, and form the effective count n (see Configuration).
  - n = 0 or op outside the shift group → DONE, with result = operand, cf = cf_in, of = 0, flags_upd = 0.
  - Otherwise → SHIFT, with counter = n.
- SHIFT:
  - Each cycle, apply one step to the working register r and carry c, then decrement the counter.
  - When the counter goes from 1 to 0 → DONE.
- DONE: `done` = 1 for one cycle, then → IDLE. `start` is ignored in this cycle.
- Step rules (msb = bit 15 for word ops, bit 7 for byte ops; for byte ops, bits 15:8 of the result pass `operand[15:8]` through unchanged):
  - ROL: r = {r[msb-1:0], r[msb]}, c = old r[msb].
  - ROR: r = {r[0], r[msb:1]}, c = old r[0].
  - ROLC: r = {r[msb-1:0], c}, c = old r[msb].
  - RORC: r = {c, r[msb:1]}, c = old r[0].
  - SHL: r = r << 1, c = old r[msb].
  - SHR: logical right shift, c = old r[0].
  - SHRA: arithmetic right shift (msb replicated), c = old r[0].
- OF is computed from the final step only:
  - ROL, ROLC, SHL: r[msb] ^ c.
  - ROR, RORC: r[msb] ^ r[msb-1].
  - SHR: r[msb] before the final step.
  - SHRA: 0.
- flags_upd = 1 for every n ≥ 1 operation.

## Timing
- `start` is sampled at edge 0.
- `done` is high in cycle n+1; n = 0 gives `done` in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- A new `start` is accepted earliest in the cycle after `done`.
- Reset values: `busy` = 0, `done` = 0, `result` = 0, `cf_out` = 0, `of_out` = 0, `flags_upd` = 0. State = IDLE, counter = 0.
- Asserting `rst_n` low mid-operation clears all state and outputs immediately and asynchronously; no `done` is produced. The first `start` after release is accepted normally.
- `result`, `cf_out`, `of_out` and `flags_upd` are registered and change only on the transition into DONE.

## Configuration
- Macro `V30MZ_SHIFT_MASK_EN`.
  - Defined: n = count & 5'h1F (at most 31 steps).
  - Undefined: n = count (full 8 bits, up to 255 steps). Rotates still iterate every step, with no modulo shortcut.

## Structure
- Shared package `alu_pkg`:
  - AluOp enum, moved out of `alu` and imported by both blocks.
  - Sequencer state enum.
  - Constants for byte/word msb index.
- Sub-module `shift_step`: combinational single-bit step.
  - Inputs: op, width16, r, c.
  - Outputs: r_next, c_next, of_next.
  - Instantiated once in the SHIFT datapath; usable later by `alu` for its single-bit ops.

## Test plan
- Word ROL, operand 0x8001, count 1 → `done` at cycle 2, result 0x0003, cf 1, of 1, flags_upd 1.
- Byte SHL, operand 0x12C3, count 3 → `done` at cycle 4, result 0x1218, cf 0, of 0; `busy` high cycles 1–4.
- Word RORC, operand 0x0001, cf_in 0, count 2 → result 0x8000, cf 0, of 1.
- SHRA, operand 0xABCD, count 0 → `done` at cycle 1, result 0xABCD, flags_upd 0. A `start` pulsed while `busy` is high in a count-5 run is ignored, with no second `done`.
- Word SHR, operand 0x0003, count 33:
  - With the macro: `done` at cycle 2, result 0x0001, cf 1, of 0.
  - Without the macro: `done` at cycle 34, result 0x0000, cf 0.
- Count 10 run, `rst_n` low at cycle 4 → all outputs 0 immediately; after release, a count-1 ROR of 0x0001 gives 0x8000, cf 1, of 1 at cycle 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: AluOp encoding, shift sequencer state, msb indices.
// Consumers: alu, shift_step, shift_sequencer.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_ADC  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_SBB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_CMP  = 4'h7,
        ALU_ROL  = 4'h8,
        ALU_ROR  = 4'h9,
        ALU_ROLC = 4'hA,
        ALU_RORC = 4'hB,
        ALU_SHL  = 4'hC,
        ALU_SHR  = 4'hD,
        ALU_SHRA = 4'hE,
        ALU_PASS = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_SHIFT = 2'd1,
        SEQ_DONE  = 2'd2
    } seq_state_e;

    localparam int MSB_BYTE = 7;
    localparam int MSB_WORD = 15;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= 4'(ALU_ROL)) && (op <= 4'(ALU_SHRA));
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step for byte or word operands.
// Byte ops leave r[15:8] untouched; non-shift ops pass r and c through with of = 0.
module shift_step
    import alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic        width16,
    input  logic [15:0] r,
    input  logic        c,
    output logic [15:0] r_next,
    output logic        c_next,
    output logic        of_next
);

    logic hi;
    logic lo;
    logic left;
    logic in_bit;
    logic nmsb;
    logic nmsb1;

    always_comb begin
        hi      = width16 ? r[MSB_WORD] : r[MSB_BYTE];
        lo      = r[0];
        left    = 1'b0;
        in_bit  = 1'b0;
        r_next  = r;
        c_next  = c;
        of_next = 1'b0;
        nmsb    = 1'b0;
        nmsb1   = 1'b0;

        if (is_shift_op(op)) begin
            unique case (alu_op_e'(op))
                ALU_ROL:  begin left = 1'b1; in_bit = hi; end
                ALU_ROLC: begin left = 1'b1; in_bit = c;  end
                ALU_SHL:  begin left = 1'b1; in_bit = 1'b0; end
                ALU_ROR:  begin left = 1'b0; in_bit = lo; end
                ALU_RORC: begin left = 1'b0; in_bit = c;  end
                ALU_SHR:  begin left = 1'b0; in_bit = 1'b0; end
                ALU_SHRA: begin left = 1'b0; in_bit = hi; end
                default:  begin left = 1'b0; in_bit = 1'b0; end
            endcase

            if (width16)
                r_next = left ? {r[14:0], in_bit} : {in_bit, r[15:1]};
            else
                r_next = {r[15:8], (left ? {r[6:0], in_bit} : {in_bit, r[7:1]})};

            c_next = left ? hi : lo;
            nmsb   = width16 ? r_next[MSB_WORD]     : r_next[MSB_BYTE];
            nmsb1  = width16 ? r_next[MSB_WORD - 1] : r_next[MSB_BYTE - 1];

            unique case (alu_op_e'(op))
                ALU_ROL, ALU_ROLC, ALU_SHL: of_next = nmsb ^ c_next;
                ALU_ROR, ALU_RORC:          of_next = nmsb ^ nmsb1;
                ALU_SHR:                    of_next = hi;
                default:                    of_next = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle counted shift/rotate unit: one single-bit step per cycle via shift_step.
// Optional macro V30MZ_SHIFT_MASK_EN limits the effective count to count[4:0].
module shift_sequencer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic        width16,
    input  logic [15:0] operand,
    input  logic [7:0]  count,
    input  logic        cf_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cf_out,
    output logic        of_out,
    output logic        flags_upd
);

    seq_state_e  state;
    logic [7:0]  cnt;
    logic [7:0]  n_eff;
    logic [3:0]  op_q;
    logic        width16_q;
    logic [15:0] r_q;
    logic        c_q;
    logic [15:0] r_next;
    logic        c_next;
    logic        of_next;
    logic        accept;

`ifdef V30MZ_SHIFT_MASK_EN
    assign n_eff = count & 8'h1F;
`else
    assign n_eff = count;
`endif

    assign accept = (state == SEQ_IDLE) && start;

    shift_step u_step (
        .op      (op_q),
        .width16 (width16_q),
        .r       (r_q),
        .c       (c_q),
        .r_next  (r_next),
        .c_next  (c_next),
        .of_next (of_next)
    );

    // Working operand and carry carry no reset: they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= op;
            width16_q <= width16;
            r_q       <= operand;
            c_q       <= cf_in;
        end else if (state == SEQ_SHIFT) begin
            r_q <= r_next;
            c_q <= c_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ_IDLE;
            cnt       <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 16'd0;
            cf_out    <= 1'b0;
            of_out    <= 1'b0;
            flags_upd <= 1'b0;
        end else begin
            unique case (state)
                SEQ_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if ((n_eff == 8'd0) || !is_shift_op(op)) begin
                            state     <= SEQ_DONE;
                            done      <= 1'b1;
                            result    <= operand;
                            cf_out    <= cf_in;
                            of_out    <= 1'b0;
                            flags_upd <= 1'b0;
                        end else begin
                            state <= SEQ_SHIFT;
                            cnt   <= n_eff;
                        end
                    end
                end
                SEQ_SHIFT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state     <= SEQ_DONE;
                        done      <= 1'b1;
                        result    <= r_next;
                        cf_out    <= c_next;
                        of_out    <= of_next;
                        flags_upd <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= SEQ_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed table-driven bench for shift_sequencer, plus hand sequences for busy-start and mid-run reset.
// Expected values for the count-33 vector follow V30MZ_SHIFT_MASK_EN.
module tb_shift_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic        width16;
    logic [15:0] operand;
    logic [7:0]  count;
    logic        cf_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cf_out;
    logic        of_out;
    logic        flags_upd;

    int errors = 0;
    int checks = 0;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .width16   (width16),
        .operand   (operand),
        .count     (count),
        .cf_in     (cf_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cf_out    (cf_out),
        .of_out    (of_out),
        .flags_upd (flags_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        w16;
        logic [15:0] operand;
        logic [7:0]  count;
        logic        cf_in;
        int          exp_done;
        logic [15:0] exp_res;
        logic        exp_cf;
        logic        exp_of;
        logic        exp_upd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic [3:0] o, input logic w, input logic [15:0] d,
                               input logic [7:0] n, input logic ci);
        @(negedge clk);
        op = o; width16 = w; operand = d; count = n; cf_in = ci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the cycle in which done was seen (0 if never within the bound) and whether busy dropped early.
    task automatic wait_done(input int limit, output int done_cyc, output logic busy_bad);
        done_cyc = 0;
        busy_bad = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   dc;
        logic bb;
        drive_start(v.op, v.w16, v.operand, v.count, v.cf_in);
        wait_done(300, dc, bb);
        chk({v.name, "_done_cycle"}, dc, v.exp_done);
        chk({v.name, "_busy"}, {31'd0, bb}, 32'd0);
        chk({v.name, "_result"}, {16'd0, result}, {16'd0, v.exp_res});
        chk({v.name, "_flags"}, {29'd0, cf_out, of_out, flags_upd},
            {29'd0, v.exp_cf, v.exp_of, v.exp_upd});
        @(posedge clk);
        #1;
        chk({v.name, "_after_done"}, {30'd0, done, busy}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int   dc;
        logic bb;
        int   extra_done;

        vecs[0]  = '{"rol_w",      4'(ALU_ROL),  1'b1, 16'h8001, 8'd1,  1'b0, 2,  16'h0003, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{"shl_b",      4'(ALU_SHL),  1'b0, 16'h12C3, 8'd3,  1'b0, 4,  16'h1218, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{"rorc_w",     4'(ALU_RORC), 1'b1, 16'h0001, 8'd2,  1'b0, 3,  16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{"shra_zero",  4'(ALU_SHRA), 1'b1, 16'hABCD, 8'd0,  1'b0, 1,  16'hABCD, 1'b0, 1'b0, 1'b0};
`ifdef V30MZ_SHIFT_MASK_EN
        vecs[4]  = '{"shr_33",     4'(ALU_SHR),  1'b1, 16'h0003, 8'd33, 1'b0, 2,  16'h0001, 1'b1, 1'b0, 1'b1};
`else
        vecs[4]  = '{"shr_33",     4'(ALU_SHR),  1'b1, 16'h0003, 8'd33, 1'b0, 34, 16'h0000, 1'b0, 1'b0, 1'b1};
`endif
        vecs[5]  = '{"ror_b",      4'(ALU_ROR),  1'b0, 16'hFF81, 8'd1,  1'b0, 2,  16'hFFC0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{"shra_w",     4'(ALU_SHRA), 1'b1, 16'h8004, 8'd2,  1'b1, 3,  16'hE001, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"rolc_b",     4'(ALU_ROLC), 1'b0, 16'h0040, 8'd2,  1'b1, 3,  16'h0002, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{"shl_w",      4'(ALU_SHL),  1'b1, 16'h4000, 8'd1,  1'b0, 2,  16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{"shr_b",      4'(ALU_SHR),  1'b0, 16'hAA80, 8'd1,  1'b1, 2,  16'hAA40, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{"add_nonshift", 4'(ALU_ADD), 1'b1, 16'h1234, 8'd3, 1'b1, 1,  16'h1234, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{"rol_w16",    4'(ALU_ROL),  1'b1, 16'h8001, 8'd16, 1'b0, 17, 16'h8001, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; op = 4'd0; width16 = 1'b0;
        operand = 16'd0; count = 8'd0; cf_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {12'd0, busy, done, result, cf_out, of_out, flags_upd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Byte rotate by a full byte width returns the original value.
        begin
            vec_t v;
            v = '{"ror_b8", 4'(ALU_ROR), 1'b0, 16'h0001, 8'd8, 1'b0, 9, 16'h0001, 1'b0, 1'b0, 1'b1};
            run_vec(v);
        end

        // start pulsed while busy is ignored: one done at cycle 6, none after.
        drive_start(4'(ALU_SHL), 1'b1, 16'h0001, 8'd5, 1'b0);
        @(negedge clk);
        op = 4'(ALU_ROR); operand = 16'hFFFF; count = 8'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        extra_done = 0;
        dc = 0;
        for (int cyc = 3; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (dc == 0) begin
                    dc = cyc;
                    chk("busy_start_result", {16'd0, result}, 32'h0020);
                end else begin
                    extra_done++;
                end
            end
        end
        chk("busy_start_done_cycle", dc, 6);
        chk("busy_start_no_second_done", extra_done, 0);

        // Asynchronous reset mid-run clears outputs at once and produces no done.
        drive_start(4'(ALU_ROL), 1'b1, 16'h1234, 8'd10, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {12'd0, busy, done, result, cf_out, of_out, flags_upd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        chk("midrun_reset_quiet", extra_done, 0);

        drive_start(4'(ALU_ROR), 1'b1, 16'h0001, 8'd1, 1'b0);
        wait_done(10, dc, bb);
        chk("post_reset_done_cycle", dc, 2);
        chk("post_reset_result", {16'd0, result}, 32'h8000);
        chk("post_reset_flags", {29'd0, cf_out, of_out, flags_upd}, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
